// File: rtl/mdu_frontend_pkg.sv
// Shared micro-op encoding and MDU frontend types/helpers.
// Op classification functions are used by both the frontend and the bench.
package micro_ops;

  typedef logic [31:0] word_t;
  typedef logic [63:0] dword_t;

  typedef enum logic [4:0] {
    OP_NONE,
    OP_ADD,
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU,
    OP_DIV,
    OP_DIVU,
    OP_REM,
    OP_REMU,
    OP_CLMUL,
    OP_CLMULH,
    OP_CLMULR
  } op_t;

  typedef enum logic [1:0] {
    FE_IDLE,
    FE_LAUNCH,
    FE_WAIT,
    FE_DONE
  } mdu_fe_state_t;

  function automatic logic is_mdu_op(op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU,
                      OP_REM, OP_REMU, OP_CLMUL, OP_CLMULH, OP_CLMULR};
  endfunction

  function automatic logic is_div_op(op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_div(op_t op);
    return op inside {OP_DIV, OP_REM};
  endfunction

  function automatic logic is_rem_op(op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/mdu_frontend_div_cache.sv
// One-entry quotient/remainder cache keyed by operands and signedness.
module mdu_div_cache
  import micro_ops::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  word_t wr_rs1,
  input  word_t wr_rs2,
  input  logic  wr_signed,
  input  word_t wr_quot,
  input  word_t wr_rem,
  input  word_t cmp_rs1,
  input  word_t cmp_rs2,
  input  logic  cmp_signed,
  output logic  hit,
  output word_t hit_quot,
  output word_t hit_rem
);

  logic  valid_q;
  logic  signed_q;
  word_t rs1_q, rs2_q, quot_q, rem_q;

  // NOTE: the entry is a handful of flops, not a RAM, so every field is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      signed_q <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
    end else if (wr_en) begin
      valid_q  <= 1'b1;
      signed_q <= wr_signed;
      rs1_q    <= wr_rs1;
      rs2_q    <= wr_rs2;
      quot_q   <= wr_quot;
      rem_q    <= wr_rem;
    end
  end

  assign hit      = valid_q && (rs1_q == cmp_rs1) && (rs2_q == cmp_rs2) && (signed_q == cmp_signed);
  assign hit_quot = quot_q;
  assign hit_rem  = rem_q;

endmodule

// File: rtl/mdu_frontend.sv
// Issue-side sequencer for the multi-cycle MDU: launches ops, resolves divide
// special cases and DIV/REM pairs locally, and returns results to writeback.
module mdu_frontend
  import micro_ops::*;
#(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              in_op,
  input  word_t            in_rs1,
  input  word_t            in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output word_t            out_result,
  output logic [TAG_W-1:0] out_tag,
  output op_t              mdu_op,
  output word_t            mdu_rs1,
  output word_t            mdu_rs2,
  output logic             mdu_flush,
  input  dword_t           mdu_mul_ss,
  input  dword_t           mdu_mul_su,
  input  dword_t           mdu_mul_uu,
  input  dword_t           mdu_clmul,
  input  dword_t           mdu_clmulr,
  input  word_t            mdu_div_s,
  input  word_t            mdu_div_u,
  input  word_t            mdu_rem_s,
  input  word_t            mdu_rem_u,
  input  logic             mdu_busy
);

  function automatic logic is_div_zero(op_t op, word_t rs2);
    return is_div_op(op) && (rs2 == '0);
  endfunction

  function automatic logic is_div_ovf(op_t op, word_t rs1, word_t rs2);
    return is_signed_div(op) && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  endfunction

  function automatic word_t select_result(op_t op, dword_t mul_ss, dword_t mul_su,
                                          dword_t mul_uu, dword_t clmul, dword_t clmulr,
                                          word_t div_s, word_t div_u,
                                          word_t rem_s, word_t rem_u);
    case (op)
      OP_MUL:    return mul_ss[31:0];
      OP_MULH:   return mul_ss[63:32];
      OP_MULHSU: return mul_su[63:32];
      OP_MULHU:  return mul_uu[63:32];
      OP_DIV:    return div_s;
      OP_DIVU:   return div_u;
      OP_REM:    return rem_s;
      OP_REMU:   return rem_u;
      OP_CLMUL:  return clmul[31:0];
      OP_CLMULH: return clmul[63:32];
      OP_CLMULR: return clmulr[31:0];
      default:   return '0;
    endcase
  endfunction

  mdu_fe_state_t    state;
  op_t              op_q;
  word_t            rs1_q, rs2_q;
  logic [TAG_W-1:0] tag_q;

  logic  cache_hit, in_hit, in_local, capture, in_busy_state;
  word_t hit_quot, hit_rem, local_result;

  assign in_ready      = (state == FE_IDLE) && !flush;
  assign mdu_flush     = flush;
  assign in_busy_state = (state == FE_LAUNCH) || (state == FE_WAIT);
  assign mdu_op        = in_busy_state ? op_q : OP_NONE;
  assign mdu_rs1       = rs1_q;
  assign mdu_rs2       = rs2_q;
  assign capture       = in_busy_state && !mdu_busy && !flush;

  assign in_hit   = is_div_op(in_op) && cache_hit;
  assign in_local = is_div_zero(in_op, in_rs2) || is_div_ovf(in_op, in_rs1, in_rs2) ||
                    in_hit || !is_mdu_op(in_op);

  // NOTE: default assignment first so no path through the block infers a latch.
  always_comb begin
    local_result = '0;
    if (is_div_zero(in_op, in_rs2))
      local_result = is_rem_op(in_op) ? in_rs1 : 32'hFFFF_FFFF;
    else if (is_div_ovf(in_op, in_rs1, in_rs2))
      local_result = is_rem_op(in_op) ? 32'h0 : 32'h8000_0000;
    else if (in_hit)
      local_result = is_rem_op(in_op) ? hit_rem : hit_quot;
  end

  mdu_div_cache u_div_cache (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (capture && is_div_op(op_q)),
    .wr_rs1     (rs1_q),
    .wr_rs2     (rs2_q),
    .wr_signed  (is_signed_div(op_q)),
    .wr_quot    (is_signed_div(op_q) ? mdu_div_s : mdu_div_u),
    .wr_rem     (is_signed_div(op_q) ? mdu_rem_s : mdu_rem_u),
    .cmp_rs1    (in_rs1),
    .cmp_rs2    (in_rs2),
    .cmp_signed (is_signed_div(in_op)),
    .hit        (cache_hit),
    .hit_quot   (hit_quot),
    .hit_rem    (hit_rem)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FE_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      op_q       <= OP_NONE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      tag_q      <= '0;
    end else if (flush) begin
      state     <= FE_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FE_IDLE: begin
          if (in_valid) begin
            if (in_local) begin
              out_valid  <= 1'b1;
              out_result <= local_result;
              out_tag    <= in_tag;
              state      <= FE_DONE;
            end else begin
              // Operands are only latched for real launches so the MDU
              // inputs hold their last launched value otherwise.
              op_q  <= in_op;
              rs1_q <= in_rs1;
              rs2_q <= in_rs2;
              tag_q <= in_tag;
              state <= FE_LAUNCH;
            end
          end
        end
        FE_LAUNCH, FE_WAIT: begin
          if (mdu_busy) begin
            state <= FE_WAIT;
          end else begin
            out_valid  <= 1'b1;
            out_result <= select_result(op_q, mdu_mul_ss, mdu_mul_su, mdu_mul_uu,
                                        mdu_clmul, mdu_clmulr, mdu_div_s, mdu_div_u,
                                        mdu_rem_s, mdu_rem_u);
            out_tag    <= tag_q;
            state      <= FE_DONE;
          end
        end
        FE_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= FE_IDLE;
          end
        end
        default: state <= FE_IDLE;
      endcase
    end
  end

endmodule
